// File: rtl/uart_cmd_pkg.sv
// Shared types and helpers for the UART command master.
package uart_cmd_pkg;
  typedef enum logic [2:0] {IDLE, SEND_OP, SEND_ADDR, SEND_DATA, WAIT_RSP, RESP} cmd_state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  function automatic int frame_clocks(input int addr_width, input int baud_period);
    return (addr_width + 2) * baud_period;
  endfunction
endpackage

// File: rtl/uart_cmd_link.sv
// Bit-level link: frame serializer with trailing idle gap, and a synchronizing
// deserializer with mid-bit start confirmation.
module uart_cmd_link import uart_cmd_pkg::*; #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int BAUD_PERIOD = 16,
  parameter int GAP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_load,
  input  logic [ADDR_WIDTH-1:0] tx_payload,
  output logic                  tx_frame_done,
  output logic                  tx_slot_done,
  output logic                  tx,
  input  logic                  rx_arm,
  input  logic                  rx,
  output logic                  rx_start_ok,
  output logic                  rx_done,
  output logic                  rx_frame_err,
  output logic [DATA_WIDTH-1:0] rx_data
);
  localparam int FRAME_CLKS = frame_clocks(ADDR_WIDTH, BAUD_PERIOD);
  localparam int SLOT_CLKS  = FRAME_CLKS + GAP_BITS * BAUD_PERIOD;
  localparam int CW = $clog2(SLOT_CLKS);
  localparam int BW = $clog2(BAUD_PERIOD);
  localparam int IW = $clog2(ADDR_WIDTH + 2);
  localparam int SW = ADDR_WIDTH + 2;
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_CLKS - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CLKS - 1);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(BAUD_PERIOD - 1);
  localparam logic [BW-1:0] HALF_LAST  = BW'(BAUD_PERIOD / 2 - 1);
  localparam logic [IW-1:0] STOP_IDX   = IW'(ADDR_WIDTH + 1);

  logic [SW-1:0]         tsh_q, tsh_d;
  logic [CW-1:0]         tcnt_q, tcnt_d;
  logic [BW-1:0]         tbaud_q, tbaud_d;
  logic                  tbusy_q, tbusy_d;
  logic [2:0]            rx_sync_q, rx_sync_d;
  logic                  ract_q, ract_d;
  logic [BW-1:0]         rcnt_q, rcnt_d;
  logic [IW-1:0]         ridx_q, ridx_d;
  logic [ADDR_WIDTH-1:0] rsh_q, rsh_d;

  assign tx            = tsh_q[0];
  assign tx_frame_done = tbusy_q && (tcnt_q == FRAME_LAST);
  assign tx_slot_done  = tbusy_q && (tcnt_q == SLOT_LAST);

  // Shifting in ones after the stop bit keeps tx high through the gap.
  always_comb begin
    tsh_d   = tsh_q;
    tcnt_d  = tcnt_q;
    tbaud_d = tbaud_q;
    tbusy_d = tbusy_q;
    if (tx_load) begin
      tsh_d   = {1'b1, tx_payload, 1'b0};
      tcnt_d  = '0;
      tbaud_d = '0;
      tbusy_d = 1'b1;
    end else if (tbusy_q) begin
      tcnt_d = tcnt_q + 1'b1;
      if (tbaud_q == BAUD_LAST) begin
        tbaud_d = '0;
        tsh_d   = {1'b1, tsh_q[SW-1:1]};
      end else begin
        tbaud_d = tbaud_q + 1'b1;
      end
      if (tx_slot_done) tbusy_d = 1'b0;
    end
  end

  // rx_sync_q[1] is the synchronized line, rx_sync_q[2] its previous value.
  assign rx_data      = rsh_q[DATA_WIDTH-1:0];
  assign rx_frame_err = ~rx_sync_q[1];

  always_comb begin
    rx_sync_d   = {rx_sync_q[1:0], rx};
    ract_d      = ract_q;
    rcnt_d      = rcnt_q;
    ridx_d      = ridx_q;
    rsh_d       = rsh_q;
    rx_start_ok = 1'b0;
    rx_done     = 1'b0;
    if (!rx_arm) begin
      ract_d = 1'b0;
    end else if (!ract_q) begin
      if (rx_sync_q[2] && !rx_sync_q[1]) begin
        ract_d = 1'b1;
        rcnt_d = '0;
        ridx_d = '0;
      end
    end else begin
      rcnt_d = rcnt_q + 1'b1;
      if (ridx_q == '0 && rcnt_q == HALF_LAST) begin
        rcnt_d = '0;
        if (rx_sync_q[1]) begin
          ract_d = 1'b0;
        end else begin
          ridx_d      = IW'(1);
          rx_start_ok = 1'b1;
        end
      end else if (ridx_q != '0 && rcnt_q == BAUD_LAST) begin
        rcnt_d = '0;
        if (ridx_q == STOP_IDX) begin
          rx_done = 1'b1;
          ract_d  = 1'b0;
        end else begin
          rsh_d  = {rx_sync_q[1], rsh_q[ADDR_WIDTH-1:1]};
          ridx_d = ridx_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tsh_q     <= '1;
      tcnt_q    <= '0;
      tbaud_q   <= '0;
      tbusy_q   <= 1'b0;
      rx_sync_q <= '1;
      ract_q    <= 1'b0;
      rcnt_q    <= '0;
      ridx_q    <= '0;
      rsh_q     <= '0;
    end else begin
      tsh_q     <= tsh_d;
      tcnt_q    <= tcnt_d;
      tbaud_q   <= tbaud_d;
      tbusy_q   <= tbusy_d;
      rx_sync_q <= rx_sync_d;
      ract_q    <= ract_d;
      rcnt_q    <= rcnt_d;
      ridx_q    <= ridx_d;
      rsh_q     <= rsh_d;
    end
  end
endmodule

// File: rtl/uart_cmd_master.sv
// Request FSM turning parallel read/write requests into opcode/address/data
// frames for the UART memory wrapper, with response capture and timeout.
module uart_cmd_master import uart_cmd_pkg::*; #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int BAUD_PERIOD    = 16,
  parameter int GAP_BITS       = 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  tx,
  input  logic                  rx
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  cmd_state_t            state_q, state_d;
  logic                  wr_q, wr_d, kick_q, kick_d, started_q, started_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  ready_q, ready_d, valid_q, valid_d, err_q, err_d;

  logic                  tx_load, tx_frame_done, tx_slot_done;
  logic [ADDR_WIDTH-1:0] tx_payload;
  logic                  rx_start_ok, rx_done, rx_frame_err;
  logic [DATA_WIDTH-1:0] rx_data;

  uart_cmd_link #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .BAUD_PERIOD(BAUD_PERIOD), .GAP_BITS(GAP_BITS)
  ) u_link (
    .clk(clk), .rst(rst),
    .tx_load(tx_load), .tx_payload(tx_payload),
    .tx_frame_done(tx_frame_done), .tx_slot_done(tx_slot_done), .tx(tx),
    .rx_arm(state_q == WAIT_RSP), .rx(rx),
    .rx_start_ok(rx_start_ok), .rx_done(rx_done),
    .rx_frame_err(rx_frame_err), .rx_data(rx_data)
  );

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    kick_d     = kick_q;
    started_d  = started_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    tmo_d      = tmo_q;
    tx_load    = 1'b0;
    tx_payload = '0;
    case (state_q)
      IDLE: if (req_valid && ready_q) begin
        state_d = SEND_OP;
        wr_d    = req_write;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        kick_d  = 1'b1;
      end
      // The opcode frame launches one cycle after acceptance; later frames
      // load back-to-back on the previous slot's last cycle.
      SEND_OP: if (kick_q) begin
        tx_load       = 1'b1;
        tx_payload[0] = wr_q ? OP_WRITE : OP_READ;
        kick_d        = 1'b0;
      end else if (tx_slot_done) begin
        tx_load    = 1'b1;
        tx_payload = addr_q;
        state_d    = SEND_ADDR;
      end
      SEND_ADDR: if (wr_q) begin
        if (tx_slot_done) begin
          tx_load    = 1'b1;
          tx_payload = ADDR_WIDTH'(wdata_q);
          state_d    = SEND_DATA;
        end
      end else if (tx_frame_done) begin
        state_d   = WAIT_RSP;
        tmo_d     = '0;
        started_d = 1'b0;
      end
      SEND_DATA: if (tx_slot_done) begin
        state_d = RESP;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      WAIT_RSP: begin
        if (rx_start_ok) started_d = 1'b1;
        else if (!started_q) tmo_d = tmo_q + 1'b1;
        if (rx_done) begin
          state_d = RESP;
          rdata_d = rx_frame_err ? '0 : rx_data;
          err_d   = rx_frame_err;
        end else if (!started_q && !rx_start_ok && tmo_q == TMO_LAST) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_q      <= 1'b0;
      kick_q    <= 1'b0;
      started_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      kick_q    <= kick_d;
      started_q <= started_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
    end
  end
endmodule
